// File: rtl/ram_dp_be_clr.sv
// ram_dp_be_clr: dual-port RAM with per-lane write enables, optional registered read
// and a clear engine that sweeps every word to init_val after reset or on request.
module ram_dp_be_clr #(
    parameter int w = 8,
    parameter int d = 16,
    parameter int d_log = $clog2(d),
    parameter int nb = 1,
    parameter int rd_reg = 0,
    parameter int wr_first = 1,
    parameter logic [w-1:0] init_val = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr,
    input  logic [nb-1:0]    wr_be,
    input  logic [d_log-1:0] addr_wr,
    input  logic [w-1:0]     data_in,
    input  logic             rd,
    input  logic [d_log-1:0] addr_rd,
    output logic [w-1:0]     data_out,
    output logic             rd_valid,
    output logic             busy
);
    localparam int lw = w / nb;
    localparam logic [d_log-1:0] last = d_log'(d - 1);
    localparam logic [d_log:0] depth = (d_log + 1)'(d);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_n;
    logic [d_log-1:0] clr_addr, clr_addr_n;
    logic [w-1:0] ram [d];
    logic [w-1:0] be_mask;
    logic wr_ok;
    assign busy = state == CLEAR;
    // out-of-range addresses only exist for non-power-of-2 depths
    assign wr_ok = wr && !busy && ({1'b0, addr_wr} < depth);
    for (genvar g = 0; g < nb; g++) begin : g_mask
        assign be_mask[g*lw +: lw] = {lw{wr_be[g]}};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_n;
            clr_addr <= clr_addr_n;
        end
    end
    // clr during a sweep is ignored; clr_addr stays at 0 while idle
    always_comb begin
        state_n = busy ? (clr_addr == last ? IDLE : CLEAR) : (clr ? CLEAR : IDLE);
        clr_addr_n = (busy && clr_addr != last) ? clr_addr + 1'b1 : '0;
    end
    always_ff @(posedge clk) begin
        if (busy)
            ram[clr_addr] <= init_val;
        else if (wr_ok)
            ram[addr_wr] <= (ram[addr_wr] & ~be_mask) | (data_in & be_mask);
    end
    if (rd_reg != 0) begin : g_reg
        logic [w-1:0] rd_word;
        // write-first collisions return the lane-merged word
        assign rd_word = (wr_first != 0 && wr_ok && addr_wr == addr_rd)
                       ? (ram[addr_rd] & ~be_mask) | (data_in & be_mask) : ram[addr_rd];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_out <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd && !busy;
                if (rd && !busy)
                    data_out <= rd_word;
            end
        end
    end else begin : g_comb
        assign data_out = ram[addr_rd];
        assign rd_valid = rd && !busy;
    end
endmodule

// File: tb/tb_ram_dp_be_clr.sv
// tb_ram_dp_be_clr: three RAM variants (combinational, registered write-first, registered
// read-first) share one stimulus stream and are checked against a word-level memory model.
module tb_ram_dp_be_clr;
    localparam int W = 32, D = 12, NB = 4;
    localparam logic [W-1:0] INIT = 32'hC3C3_00FF;
    logic clk = 0, rst_n = 1, clr = 0, wr = 0, rd = 0;
    logic [NB-1:0] wr_be = '0;
    logic [3:0] addr_wr = '0, addr_rd = '0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] c_do, wf_do, rf_do;
    logic c_v, wf_v, rf_v, c_b, wf_b, rf_b;
    int total = 0, bad = 0;
    logic [W-1:0] mem [D];
    int busy_left;
    logic [W-1:0] q_wf[$], q_rf[$];
    logic [W-1:0] last_wf, last_rf, m_old;

    always #5 clk = ~clk;

    ram_dp_be_clr #(.w(W), .d(D), .nb(NB), .rd_reg(0), .init_val(INIT)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .wr_be(wr_be), .addr_wr(addr_wr),
        .data_in(data_in), .rd(rd), .addr_rd(addr_rd), .data_out(c_do), .rd_valid(c_v), .busy(c_b));
    ram_dp_be_clr #(.w(W), .d(D), .nb(NB), .rd_reg(1), .wr_first(1), .init_val(INIT)) u_wf (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .wr_be(wr_be), .addr_wr(addr_wr),
        .data_in(data_in), .rd(rd), .addr_rd(addr_rd), .data_out(wf_do), .rd_valid(wf_v), .busy(wf_b));
    ram_dp_be_clr #(.w(W), .d(D), .nb(NB), .rd_reg(1), .wr_first(0), .init_val(INIT)) u_rf (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .wr_be(wr_be), .addr_wr(addr_wr),
        .data_in(data_in), .rd(rd), .addr_rd(addr_rd), .data_out(rf_do), .rd_valid(rf_v), .busy(rf_b));

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] di,
                                           input logic [NB-1:0] be);
        logic [W-1:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~m) | (di & m);
    endfunction

    // a clear is observably equivalent to filling everything at once: nothing is visible while busy
    task automatic mreset();
        busy_left = D;
        foreach (mem[i]) mem[i] = INIT;
        q_wf.delete();
        q_rf.delete();
        last_wf = '0;
        last_rf = '0;
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            if (rd && busy_left == 0) begin
                m_old = mem[addr_rd];
                q_rf.push_back(m_old);
                q_wf.push_back((wr && addr_wr == addr_rd) ? merge(m_old, data_in, wr_be) : m_old);
            end
            if (wr && busy_left == 0 && addr_wr < D)
                mem[addr_wr] = merge(mem[addr_wr], data_in, wr_be);
            if (busy_left > 0)
                busy_left--;
            else if (clr) begin
                busy_left = D;
                foreach (mem[i]) mem[i] = INIT;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            chk("busy_c", c_b, busy_left > 0);
            chk("busy_wf", wf_b, busy_left > 0);
            chk("busy_rf", rf_b, busy_left > 0);
            chk("valid_c", c_v, rd && busy_left == 0);
            if (rd && busy_left == 0)
                chk("data_c", c_do, mem[addr_rd]);
        end
    end

    always @(posedge clk) begin
        #2;
        if (wf_v) begin
            if (q_wf.size() == 0) begin
                total++; bad++;
                $display("FAIL spur_wf: got rd_valid=1 want no pending read at %0t", $time);
            end else begin
                last_wf = q_wf.pop_front();
                chk("data_wf", wf_do, last_wf);
            end
        end else
            chk("hold_wf", wf_do, last_wf);
        if (rf_v) begin
            if (q_rf.size() == 0) begin
                total++; bad++;
                $display("FAIL spur_rf: got rd_valid=1 want no pending read at %0t", $time);
            end else begin
                last_rf = q_rf.pop_front();
                chk("data_rf", rf_do, last_rf);
            end
        end else
            chk("hold_rf", rf_do, last_rf);
        chk("lag_wf", q_wf.size(), 0);
        chk("lag_rf", q_rf.size(), 0);
    end

    task automatic step(input logic c, input logic w_, input logic [3:0] be, input logic [3:0] aw,
                        input logic [W-1:0] di, input logic r, input logic [3:0] ar);
        @(negedge clk);
        clr = c; wr = w_; wr_be = be; addr_wr = aw; data_in = di; rd = r; addr_rd = ar;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic read_all();
        for (int a = 0; a < D; a++) step(0, 0, 0, 0, 0, 1, 4'(a));
    endtask

    task automatic rst_pulse(input int n);
        @(negedge clk);
        rst_n = 0; clr = 0; wr = 0; rd = 0;
        mreset();
        #1;
        chk("rst_busy", wf_b, 1);
        chk("rst_v_wf", wf_v, 0);
        chk("rst_d_wf", wf_do, 0);
        chk("rst_v_rf", rf_v, 0);
        repeat (n) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        mreset();
        wr = 1; wr_be = 4'hF; addr_wr = 3; data_in = 32'h1234_5678; rd = 1; addr_rd = 0;
        #1 rst_n = 0;
        #1;
        chk("init_busy", c_b, 1);
        chk("init_v_wf", wf_v, 0);
        chk("init_d_wf", wf_do, 0);
        chk("init_d_rf", rf_do, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        // writes and reads hammered throughout the post-reset sweep must all be dropped
        for (int i = 0; i < D - 1; i++)
            step(0, 1, 4'($urandom), 4'($urandom_range(0, D - 1)), $urandom, 1, 4'($urandom_range(0, D - 1)));
        read_all();
        step(0, 1, 4'hF, 3, 32'hAABB_CCDD, 0, 0);
        step(0, 1, 4'b0101, 3, 32'h1122_3344, 0, 0);
        step(0, 0, 0, 0, 0, 1, 3);
        #1 chk("be_merge", c_do, 32'hAA22_CC44);
        step(0, 1, 4'hF, 5, 0, 0, 0);
        step(0, 1, 4'b0011, 5, 32'hDEAD_BEEF, 1, 5);
        @(posedge clk);
        #3;
        chk("coll_wf", wf_do, 32'h0000_BEEF);
        chk("coll_rf", rf_do, 0);
        chk("coll_v", wf_v, 1);
        step(0, 1, 4'hF, 7, 32'h5A, 0, 0);
        step(0, 0, 0, 0, 0, 1, 7);
        @(posedge clk);
        #3;
        chk("pulse_v", wf_v, 1);
        chk("pulse_d", wf_do, 32'h5A);
        idle(2);
        @(posedge clk);
        #3;
        chk("after_v", wf_v, 0);
        chk("after_d", wf_do, 32'h5A);
        step(0, 0, 0, 0, 0, 1, 7);
        @(posedge clk);
        rst_pulse(1);
        idle(D + 1);
        for (int a = 0; a < D; a++) step(0, 1, 4'hF, 4'(a), 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 4'hF, 4'($urandom_range(0, D - 1)), $urandom, 1, 4'($urandom_range(0, D - 1)));
        step(1, 0, 0, 0, 0, 1, 2);
        for (int i = 0; i < D; i++) step(0, 0, 0, 0, 0, 1, 4'($urandom_range(0, D - 1)));
        read_all();
        step(1, 0, 0, 0, 0, 0, 0);
        idle(6);
        rst_pulse(2);
        idle(D);
        read_all();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0)
                rst_pulse($urandom_range(1, 3));
            step($urandom_range(0, 59) == 0, 1'($urandom), 4'($urandom), 4'($urandom),
                 $urandom, $urandom_range(0, 4) != 0, 4'($urandom_range(0, D - 1)));
        end
        idle(2);
        @(posedge clk);
        #3;
        chk("drain_wf", q_wf.size(), 0);
        chk("drain_rf", q_rf.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
